// File: rtl/pipeline_hazard_feed.sv
// Pipeline-register control bank: carries hazard-relevant fields through IF/ID, ID/EX,
// EX/MEM and MEM/WB, applies stall/flush commands, and counts stall/flush cycles.
module pipeline_hazard_feed #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             if_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwr,
    input  logic             id_branch,
    input  logic             id_branch_neq,
    input  logic             id_jump,
    input  logic             ex_equal,
    input  logic             dcache_hit,
    input  logic             stall_ifid,
    input  logic             stall_idex,
    input  logic             stall_xmem,
    input  logic             stall_wb,
    input  logic             flush_ifid,
    input  logic             flush_idex,
    input  logic             flush_xmem,
    input  logic             flush_wb,
    output logic [REG_W-1:0] idex_rs,
    output logic [REG_W-1:0] mwb_rd,
    output logic             branch,
    output logic             branch_neq,
    output logic             jump,
    output logic             is_equal,
    output logic             dhit,
    output logic             take_branch,
    output logic [3:0]       stage_valid,
    output logic             wb_regwr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             r_ifid_v;
    logic             r_idex_v, r_idex_regwr, r_idex_br, r_idex_bne, r_idex_j;
    logic [REG_W-1:0] r_idex_rs, r_idex_rd;
    logic             r_xm_v, r_xm_regwr, r_xm_br, r_xm_bne, r_xm_j, r_xm_eq;
    logic [REG_W-1:0] r_xm_rd;
    logic             r_mw_v, r_mw_regwr;
    logic [REG_W-1:0] r_mw_rd;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    // A latch that is both stalled and flushed is cleared, not held, so it does not
    // force a bubble downstream.
    logic w_hold_ifid, w_hold_idex, w_hold_xmem, w_any_stall, w_any_flush;
    assign w_hold_ifid = stall_ifid & ~flush_ifid;
    assign w_hold_idex = stall_idex & ~flush_idex;
    assign w_hold_xmem = stall_xmem & ~flush_xmem;
    assign w_any_stall = stall_ifid | stall_idex | stall_xmem | stall_wb;
    assign w_any_flush = flush_ifid | flush_idex | flush_xmem | flush_wb;

    always_ff @(posedge CLK) begin
        if (RST || flush_ifid) r_ifid_v <= 1'b0;
        else if (!stall_ifid)  r_ifid_v <= if_valid;
    end

    always_ff @(posedge CLK) begin
        if (RST || flush_idex || (!stall_idex && w_hold_ifid)) begin
            r_idex_v     <= 1'b0;
            r_idex_rs    <= '0;
            r_idex_rd    <= '0;
            r_idex_regwr <= 1'b0;
            r_idex_br    <= 1'b0;
            r_idex_bne   <= 1'b0;
            r_idex_j     <= 1'b0;
        end else if (!stall_idex) begin
            r_idex_v     <= r_ifid_v;
            r_idex_rs    <= r_ifid_v ? id_rs : '0;
            r_idex_rd    <= r_ifid_v ? id_rd : '0;
            r_idex_regwr <= r_ifid_v & id_regwr;
            r_idex_br    <= r_ifid_v & id_branch;
            r_idex_bne   <= r_ifid_v & id_branch_neq;
            r_idex_j     <= r_ifid_v & id_jump;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || flush_xmem || (!stall_xmem && w_hold_idex)) begin
            r_xm_v     <= 1'b0;
            r_xm_rd    <= '0;
            r_xm_regwr <= 1'b0;
            r_xm_br    <= 1'b0;
            r_xm_bne   <= 1'b0;
            r_xm_j     <= 1'b0;
            r_xm_eq    <= 1'b0;
        end else if (!stall_xmem) begin
            r_xm_v     <= r_idex_v;
            r_xm_rd    <= r_idex_rd;
            r_xm_regwr <= r_idex_regwr;
            r_xm_br    <= r_idex_br;
            r_xm_bne   <= r_idex_bne;
            r_xm_j     <= r_idex_j;
            r_xm_eq    <= r_idex_v & ex_equal;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || flush_wb || (!stall_wb && w_hold_xmem)) begin
            r_mw_v     <= 1'b0;
            r_mw_rd    <= '0;
            r_mw_regwr <= 1'b0;
        end else if (!stall_wb) begin
            r_mw_v     <= r_xm_v;
            r_mw_rd    <= r_xm_regwr ? r_xm_rd : '0;
            r_mw_regwr <= r_xm_regwr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_any_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_any_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // Fields are zeroed whenever a latch goes invalid, so the registers already carry the gating.
    assign idex_rs     = r_idex_rs;
    assign mwb_rd      = r_mw_rd;
    assign branch      = r_xm_br;
    assign branch_neq  = r_xm_bne;
    assign jump        = r_xm_j;
    assign is_equal    = r_xm_eq;
    assign dhit        = dcache_hit;
    assign take_branch = r_xm_v & ((r_xm_br & r_xm_eq) | (r_xm_bne & ~r_xm_eq));
    assign stage_valid = {r_mw_v, r_xm_v, r_idex_v, r_ifid_v};
    assign wb_regwr    = r_mw_v & r_mw_regwr;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_feed.sv
// Directed bench for pipeline_hazard_feed: reset, flow latency, stall bubbles,
// branch resolution, stall/flush priority and counter saturation (CNT_W=4).
module tb_pipeline_hazard_feed;

    logic       CLK = 1'b0;
    logic       RST;
    logic       if_valid, id_regwr, id_branch, id_branch_neq, id_jump, ex_equal, dcache_hit;
    logic [4:0] id_rs, id_rd;
    logic       stall_ifid, stall_idex, stall_xmem, stall_wb;
    logic       flush_ifid, flush_idex, flush_xmem, flush_wb;
    logic [4:0] idex_rs, mwb_rd;
    logic       branch, branch_neq, jump, is_equal, dhit, take_branch, wb_regwr;
    logic [3:0] stage_valid;
    logic [3:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    pipeline_hazard_feed #(.REG_W(5), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .if_valid(if_valid), .id_rs(id_rs), .id_rd(id_rd),
        .id_regwr(id_regwr), .id_branch(id_branch), .id_branch_neq(id_branch_neq),
        .id_jump(id_jump), .ex_equal(ex_equal), .dcache_hit(dcache_hit),
        .stall_ifid(stall_ifid), .stall_idex(stall_idex), .stall_xmem(stall_xmem),
        .stall_wb(stall_wb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_xmem(flush_xmem), .flush_wb(flush_wb), .idex_rs(idex_rs), .mwb_rd(mwb_rd),
        .branch(branch), .branch_neq(branch_neq), .jump(jump), .is_equal(is_equal),
        .dhit(dhit), .take_branch(take_branch), .stage_valid(stage_valid),
        .wb_regwr(wb_regwr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RST = 1'b0; if_valid = 1'b0; id_rs = '0; id_rd = '0; id_regwr = 1'b0;
        id_branch = 1'b0; id_branch_neq = 1'b0; id_jump = 1'b0; ex_equal = 1'b0;
        dcache_hit = 1'b0; stall_ifid = 1'b0; stall_idex = 1'b0; stall_xmem = 1'b0;
        stall_wb = 1'b0; flush_ifid = 1'b0; flush_idex = 1'b0; flush_xmem = 1'b0;
        flush_wb = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            {if_valid, id_regwr, id_branch, id_branch_neq, id_jump, ex_equal} = 6'($urandom);
            {stall_ifid, stall_idex, stall_xmem, stall_wb} = 4'($urandom);
            {flush_ifid, flush_idex, flush_xmem, flush_wb} = 4'($urandom);
            id_rs = 5'($urandom); id_rd = 5'($urandom); dcache_hit = 1'($urandom);
            tick();
        end
        checks++; if (stage_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=0000", stage_valid); end
        checks++; if (idex_rs !== 5'd0) begin failures++; $display("FAIL reset_idex_rs got=%0d exp=0", idex_rs); end
        checks++; if (mwb_rd !== 5'd0) begin failures++; $display("FAIL reset_mwb_rd got=%0d exp=0", mwb_rd); end
        checks++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
        checks++; if ({branch, branch_neq, jump, is_equal, take_branch, wb_regwr} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {branch, branch_neq, jump, is_equal, take_branch, wb_regwr}); end
        idle();
        dcache_hit = 1'b1; #1;
        checks++; if (dhit !== 1'b1) begin failures++; $display("FAIL dhit_high got=%b exp=1", dhit); end
        dcache_hit = 1'b0; #1;
        checks++; if (dhit !== 1'b0) begin failures++; $display("FAIL dhit_low got=%b exp=0", dhit); end
    endtask

    task automatic test_flow();
        do_reset();
        if_valid = 1'b1;
        tick();
        checks++; if (stage_valid !== 4'b0001) begin failures++; $display("FAIL flow_ifid got=%b exp=0001", stage_valid); end
        if_valid = 1'b0; id_rs = 5'd3; id_rd = 5'd7; id_regwr = 1'b1;
        tick();
        checks++; if (idex_rs !== 5'd3) begin failures++; $display("FAIL flow_idex_rs got=%0d exp=3", idex_rs); end
        checks++; if (stage_valid !== 4'b0010) begin failures++; $display("FAIL flow_idex_valid got=%b exp=0010", stage_valid); end
        id_rs = 5'd0; id_rd = 5'd0; id_regwr = 1'b0;
        tick();
        checks++; if (stage_valid !== 4'b0100 || idex_rs !== 5'd0 || mwb_rd !== 5'd0) begin failures++; $display("FAIL flow_exmem got=%b/%0d/%0d exp=0100/0/0", stage_valid, idex_rs, mwb_rd); end
        tick();
        checks++; if (mwb_rd !== 5'd7) begin failures++; $display("FAIL flow_mwb_rd got=%0d exp=7", mwb_rd); end
        checks++; if (wb_regwr !== 1'b1 || stage_valid !== 4'b1000) begin failures++; $display("FAIL flow_wb got=%b/%b exp=1/1000", wb_regwr, stage_valid); end
        tick();
        checks++; if (mwb_rd !== 5'd0 || wb_regwr !== 1'b0 || stage_valid !== 4'b0000) begin failures++; $display("FAIL flow_drain got=%0d/%b/%b exp=0/0/0000", mwb_rd, wb_regwr, stage_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        if_valid = 1'b1;
        tick();
        id_rs = 5'd5;
        tick();
        checks++; if (idex_rs !== 5'd5) begin failures++; $display("FAIL stall_setup got=%0d exp=5", idex_rs); end
        id_rs = 5'd9; stall_ifid = 1'b1; stall_idex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (idex_rs !== 5'd5) begin failures++; $display("FAIL stall_hold_rs[%0d] got=%0d exp=5", i, idex_rs); end
            checks++; if (stage_valid !== 4'b0011) begin failures++; $display("FAIL stall_bubble[%0d] got=%b exp=0011", i, stage_valid); end
        end
        checks++; if (stall_cnt !== 4'd3) begin failures++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
        stall_ifid = 1'b0; stall_idex = 1'b0; if_valid = 1'b0;
        tick();
        checks++; if (idex_rs !== 5'd9 || stage_valid !== 4'b0110) begin failures++; $display("FAIL stall_release got=%0d/%b exp=9/0110", idex_rs, stage_valid); end
        checks++; if (stall_cnt !== 4'd3 || flush_cnt !== 4'd0) begin failures++; $display("FAIL stall_cnt_after got=%0d/%0d exp=3/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_branch();
        // {branch, branch_neq, jump, ex_equal} -> expected take_branch
        logic [4:0] vec [3];
        vec[0] = 5'b1_0_0_1_1;
        vec[1] = 5'b0_1_0_1_0;
        vec[2] = 5'b0_1_1_0_1;
        for (int i = 0; i < 3; i++) begin
            logic [4:0] v;
            v = vec[i];
            do_reset();
            if_valid = 1'b1;
            tick();
            if_valid = 1'b0; id_branch = v[4]; id_branch_neq = v[3]; id_jump = v[2];
            tick();
            id_branch = 1'b0; id_branch_neq = 1'b0; id_jump = 1'b0; ex_equal = v[1];
            tick();
            ex_equal = 1'b0;
            checks++; if ({branch, branch_neq, jump, is_equal} !== v[4:1]) begin failures++; $display("FAIL branch_flags[%0d] got=%b exp=%b", i, {branch, branch_neq, jump, is_equal}, v[4:1]); end
            checks++; if (take_branch !== v[0]) begin failures++; $display("FAIL take_branch[%0d] got=%b exp=%b", i, take_branch, v[0]); end
            tick();
            checks++; if ({take_branch, branch, branch_neq, jump, is_equal} !== 5'b0) begin failures++; $display("FAIL branch_gone[%0d] got=%b exp=00000", i, {take_branch, branch, branch_neq, jump, is_equal}); end
        end
    endtask

    task automatic test_priority();
        do_reset();
        if_valid = 1'b1;
        tick();
        if_valid = 1'b0; id_rd = 5'd4; id_regwr = 1'b1;
        tick();
        id_rd = 5'd0; id_regwr = 1'b0;
        tick();
        checks++; if (stage_valid !== 4'b0100) begin failures++; $display("FAIL prio_setup got=%b exp=0100", stage_valid); end
        stall_xmem = 1'b1;
        tick();
        checks++; if (stage_valid !== 4'b0100 || stall_cnt !== 4'd1 || flush_cnt !== 4'd0) begin failures++; $display("FAIL prio_stall_only got=%b/%0d/%0d exp=0100/1/0", stage_valid, stall_cnt, flush_cnt); end
        flush_xmem = 1'b1;
        tick();
        checks++; if (stage_valid[2] !== 1'b0) begin failures++; $display("FAIL prio_flush_wins got=%b exp=0", stage_valid[2]); end
        checks++; if (stall_cnt !== 4'd2 || flush_cnt !== 4'd1) begin failures++; $display("FAIL prio_counters got=%0d/%0d exp=2/1", stall_cnt, flush_cnt); end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        stall_wb = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14 || i == 15 || i == 20) begin
                checks++; if (stall_cnt !== ((i < 15) ? 4'(i) : 4'd15)) begin failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, stall_cnt, (i < 15) ? i : 15); end
            end
        end
        checks++; if (flush_cnt !== 4'd0) begin failures++; $display("FAIL sat_flush got=%0d exp=0", flush_cnt); end
        flush_idex = 1'b1;
        RST = 1'b1;
        tick();
        checks++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin failures++; $display("FAIL sat_reset got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
        idle();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        if_valid = 1'b1;
        tick();
        tick();
        stall_ifid = 1'b1; stall_idex = 1'b1;
        tick();
        checks++; if (stage_valid !== 4'b0011) begin failures++; $display("FAIL midrst_setup got=%b exp=0011", stage_valid); end
        RST = 1'b1;
        tick();
        checks++; if (stage_valid !== 4'b0000 || idex_rs !== 5'd0) begin failures++; $display("FAIL midrst_clear got=%b/%0d exp=0000/0", stage_valid, idex_rs); end
        RST = 1'b0; stall_ifid = 1'b0; stall_idex = 1'b0;
        tick();
        checks++; if (stage_valid !== 4'b0001) begin failures++; $display("FAIL midrst_reload got=%b exp=0001", stage_valid); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_flow();
        test_stall();
        test_branch();
        test_priority();
        test_saturation();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
